// File: rtl/psg_pkg.sv
// Shared PSG definitions: envelope shape-bit positions and envelope state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package psg_pkg;

  // Bit positions inside the 4-bit shape word {continue, attack, alternate, hold}
  localparam int SHAPE_HOLD = 0;
  localparam int SHAPE_ALT  = 1;
  localparam int SHAPE_ATT  = 2;
  localparam int SHAPE_CONT = 3;

  typedef enum logic {
    ENV_RUN  = 1'b0,
    ENV_HOLD = 1'b1
  } env_state_e;

endpackage

// File: rtl/envelope_period_divider.sv
// Envelope timebase: CLOCK_DIV prescaler feeding a period counter that emits step_event.
// Latency: step_event fires max(period,1)*CLOCK_DIV cycles after clear; period is used live.
// Backpressure: none; clear is a synchronous restart and wins over a coincident event.
module envelope_period_divider #(
  parameter int PERIOD_BITS = 16,
  parameter int CLOCK_DIV   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [PERIOD_BITS-1:0] period,
  output logic                   step_event
);

  localparam int PRESC_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLOCK_DIV - 1);

  logic [PRESC_W-1:0]     presc_q, presc_d;
  logic [PERIOD_BITS-1:0] pcnt_q, pcnt_d;
  logic                   tick;
  logic [PERIOD_BITS:0]   pcnt_inc;
  logic [PERIOD_BITS:0]   period_eff;

  // Next-state for prescaler and period counter; a period of 0 counts as 1.
  always_comb begin
    tick       = (presc_q == PRESC_LAST);
    pcnt_inc   = {1'b0, pcnt_q} + (PERIOD_BITS + 1)'(1);
    period_eff = (period == '0) ? (PERIOD_BITS + 1)'(1) : {1'b0, period};
    presc_d    = presc_q;
    pcnt_d     = pcnt_q;
    step_event = 1'b0;
    if (clear) begin
      presc_d = '0;
      pcnt_d  = '0;
    end else if (tick) begin
      presc_d = '0;
      // >= so that a counter already past a newly shortened period wraps now
      if (pcnt_inc >= period_eff) begin
        pcnt_d     = '0;
        step_event = 1'b1;
      end else begin
        pcnt_d = pcnt_inc[PERIOD_BITS-1:0];
      end
    end else begin
      presc_d = presc_q + PRESC_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
    end
  end

endmodule

// File: rtl/envelope_gen.sv
// AY/YM style envelope generator: ramps, sawtooth/triangle repeats and hold per shape word.
// Latency: level and step pulse update the cycle after each internal step_event.
// Backpressure: none; shape_wr restarts immediately and overrides a coincident step.
module envelope_gen
  import psg_pkg::*;
#(
  parameter int PERIOD_BITS   = 16,
  parameter int ENVELOPE_BITS = 4,
  parameter int CLOCK_DIV     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               shape,
  input  logic                     shape_wr,
  input  logic [PERIOD_BITS-1:0]   period,
  output logic [ENVELOPE_BITS-1:0] out,
  output logic                     step,
  output logic                     holding
);

  localparam logic [ENVELOPE_BITS-1:0] ENV_MAX = '1;

  logic                     step_event;
  env_state_e               state_q, state_d;
  logic [3:0]               shape_q, shape_d;
  logic [ENVELOPE_BITS-1:0] cnt_q, cnt_d;
  logic                     invert_q, invert_d;
  logic                     step_q, step_d;
  logic                     hold_e, alt_e;

  envelope_period_divider #(
    .PERIOD_BITS(PERIOD_BITS),
    .CLOCK_DIV  (CLOCK_DIV)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .clear     (shape_wr),
    .period    (period),
    .step_event(step_event)
  );

  // Level sequencing: restart on shape_wr, otherwise advance on each step_event while running.
  always_comb begin
    // Without continue the envelope always ends in hold, and direction follows attack.
    hold_e   = shape_q[SHAPE_HOLD] | ~shape_q[SHAPE_CONT];
    alt_e    = shape_q[SHAPE_CONT] ? shape_q[SHAPE_ALT] : shape_q[SHAPE_ATT];
    state_d  = state_q;
    shape_d  = shape_q;
    cnt_d    = cnt_q;
    invert_d = invert_q;
    step_d   = 1'b0;
    if (shape_wr) begin
      shape_d  = shape;
      cnt_d    = '0;
      invert_d = ~shape[SHAPE_ATT];
      state_d  = ENV_RUN;
    end else if (state_q == ENV_RUN && step_event) begin
      step_d = 1'b1;
      if (cnt_q != ENV_MAX) begin
        cnt_d = cnt_q + ENVELOPE_BITS'(1);
      end else if (hold_e) begin
        state_d = ENV_HOLD;
      end else if (alt_e) begin
        invert_d = ~invert_q;
        cnt_d    = '0;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Envelope state registers; reset leaves a falling ramp armed (shape 0000).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ENV_RUN;
      shape_q  <= 4'b0000;
      cnt_q    <= '0;
      invert_q <= 1'b1;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shape_q  <= shape_d;
      cnt_q    <= cnt_d;
      invert_q <= invert_d;
      step_q   <= step_d;
    end
  end

  // Outputs decoded from registers only, so no input reaches them combinationally.
  always_comb begin
    holding = (state_q == ENV_HOLD);
    step    = step_q;
    if (holding) begin
      out = (shape_q[SHAPE_ATT] ^ alt_e) ? ENV_MAX : '0;
    end else begin
      out = invert_q ? (ENV_MAX - cnt_q) : cnt_q;
    end
  end

endmodule
